i2c_target: RTL
===============

Name: i2c_target

Overview:
- 7-bit-address I2C target (responder), the counterpart of the team's I2C initiator block.
- Oversamples SCL/SDA with a system clock and detects START, repeated START and STOP.
- Address-matches, ACKs, and delivers received bytes to local logic; serves read bytes from local logic.
- Sits at the chip pad boundary; open-drain drive via sda_oe.

Parameters:
- ADDR, 7'h42, target address compared against the first 7 bits after START.

Ports:
- clk  input  1  system clock; must be at least 8x the SCL frequency.
- rst  input  1  asynchronous, active-low reset.
- scl_in  input  1  SCL pad input, asynchronous to clk.
- sda_in  input  1  SDA pad input, asynchronous to clk.
- sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
- rx_data  output  8  last byte written by the initiator.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- tx_data  input  8  byte to return on reads; sampled when tx_ack pulses.
- tx_ack  output  1  one-clk pulse when tx_data is loaded into the shifter.
- busy  output  1  1 whenever state != IDLE.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, sda_oe=0, rx_data=0, rx_valid=0, tx_ack=0, busy=0, bit_cnt=0, shift=0. Synchronizers reset to 1.
- Input path:
  - 2-flop synchronizer per line, plus a previous-value register.
  - SCL rise/fall are recognised on the clk edge where stage 2 differs from previous.
  - START = SDA falling while synchronized SCL=1. STOP = SDA rising while SCL=1.
  - Pin change to registered response is 3 clk.
- Bit timing: data is sampled on SCL rise (MSB first); sda_oe changes only on SCL fall, except on START/STOP.
- States: IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK.
- IDLE: sda_oe=0; START -> ADDR with bit_cnt=0.
- ADDR:
  - Shift 8 bits.
  - On the SCL fall after bit 8: if shift[7:1]==ADDR -> ADDR_ACK with sda_oe=1.
  - Otherwise -> IDLE; bus is ignored until the next START.
- ADDR_ACK: hold sda_oe=1 through the 9th SCL rise. On the next SCL fall:
  - shift[0]==0 (write) -> WRITE, sda_oe=0, bit_cnt=0.
  - shift[0]==1 (read) -> READ. Load tx_data into shift, pulse tx_ack, set sda_oe = ~tx_data[7].
- WRITE:
  - Shift 8 bits.
  - On the SCL fall after bit 8: rx_data<=shift, rx_valid=1 for one clk, sda_oe=1 -> WRITE_ACK.
  - On the next SCL fall: sda_oe=0, bit_cnt=0 -> WRITE.
  - rx_data holds until the next completed byte.
- READ:
  - On each SCL fall, drive the next bit (sda_oe = ~bit).
  - On the SCL fall after bit 8: sda_oe=0 -> READ_ACK.
- READ_ACK:
  - Sample SDA on the 9th SCL rise.
  - 0 (ACK): on the next SCL fall, load tx_data, pulse tx_ack, drive its MSB -> READ.
  - 1 (NACK): -> IDLE with sda_oe=0.
- Repeated START in any state: -> ADDR, sda_oe=0, bit_cnt=0, same clk. No rx_valid is issued for a partial byte.
- STOP in any state: -> IDLE, sda_oe=0; a partial byte is discarded.
- Simultaneous events: START/STOP take priority over SCL edges.
- bit_cnt is 3-bit; the byte completes at the count of 8, tracked by a 4-bit counter or a wrap flag; no overflow into the next byte.
- sda_oe is never asserted while SCL is high, except during ACK bits and driven read data bits.
- No clock stretching: sda_oe is the only driven output.

Test Plan:
- Reset: rst low mid-transfer (during WRITE bit 4) -> sda_oe=0, busy=0 within 1 clk. Release rst, send START+0x84 -> ACK asserted.
- Write: START, 0x84 (0x42, W), 0xA5, STOP -> sda_oe=1 on both 9th bits; rx_data=0xA5 with a one-clk rx_valid; busy=0 after STOP.
- Read: START, 0x85; tx_data=0x3C then 0xC3; initiator ACKs byte 1 and NACKs byte 2 -> SDA carries 0x3C then 0xC3; two tx_ack pulses; IDLE after NACK.
- Address mismatch: START, 0x86 (0x43) -> sda_oe stays 0 for the entire frame; no rx_valid; busy=0 after the 8th fall.
- Repeated START after 3 data bits of a write -> no rx_valid; new address 0x85 is ACKed and a read proceeds.
- STOP after 5 bits of the second write byte -> rx_valid only for byte 1; IDLE; sda_oe=0.

Source files
------------

// File: rtl/i2c_target.sv
// 7-bit-address I2C target. SCL/SDA are oversampled by clk through 2-flop
// synchronizers; START/STOP/SCL edges are detected on the synchronized
// copies and drive a single registered FSM. SDA is driven open-drain via
// sda_oe (1 = pull low).
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | bus ignored until the next START
// ADDR       | shifting in the 7-bit address plus R/W bit
// ADDR_ACK   | driving ACK for a matched address
// WRITE      | shifting in a data byte from the initiator
// WRITE_ACK  | driving ACK for a received byte
// READ       | driving a data byte from tx_data, MSB first
// READ_ACK   | released, sampling the initiator's ACK/NACK
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE,
    S_WRITE_ACK,
    S_READ,
    S_READ_ACK
  } state_t;

  logic       scl_s1_q, scl_s2_q, scl_prev_q;
  logic       sda_s1_q, sda_s2_q, sda_prev_q;
  logic       scl_rise, scl_fall, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic       byte_done;

  state_t     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       sda_oe_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q;
  logic       tx_ack_q;

  // Two-stage synchronizers plus a previous-value stage for edge detection.
  // Idle bus level is high, so everything resets to 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_s1_q   <= scl_in;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= sda_in;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;
    end
  end

  assign scl_rise  =  scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q &  scl_prev_q;
  assign sda_rise  =  sda_s2_q & ~sda_prev_q;
  assign sda_fall  = ~sda_s2_q &  sda_prev_q;
  assign start_det =  sda_fall &  scl_s2_q;
  assign stop_det  =  sda_rise &  scl_s2_q;

  // Bit counter runs 0..8; bit 3 set means a full byte has been clocked.
  assign byte_done = bit_cnt_q[3];

  // Protocol FSM; START/STOP override any SCL edge seen in the same clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'd0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_ack_q   <= 1'b0;
      if (start_det) begin
        state_q   <= S_ADDR;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else if (stop_det) begin
        state_q   <= S_IDLE;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= 4'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sda_oe_q <= 1'b0;
          end
          S_ADDR: begin
            if (scl_rise && !byte_done) begin
              shift_q   <= {shift_q[6:0], sda_s2_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && byte_done) begin
              if (shift_q[7:1] == ADDR) begin
                state_q  <= S_ADDR_ACK;
                sda_oe_q <= 1'b1;
              end else begin
                state_q  <= S_IDLE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 4'd0;
              if (!shift_q[0]) begin
                state_q  <= S_WRITE;
                sda_oe_q <= 1'b0;
              end else begin
                state_q  <= S_READ;
                shift_q  <= tx_data;
                tx_ack_q <= 1'b1;
                sda_oe_q <= ~tx_data[7];
              end
            end
          end
          S_WRITE: begin
            if (scl_rise && !byte_done) begin
              shift_q   <= {shift_q[6:0], sda_s2_q};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && byte_done) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              sda_oe_q   <= 1'b1;
              state_q    <= S_WRITE_ACK;
            end
          end
          S_WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe_q  <= 1'b0;
              bit_cnt_q <= 4'd0;
              state_q   <= S_WRITE;
            end
          end
          S_READ: begin
            if (scl_rise && !byte_done) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (byte_done) begin
                sda_oe_q <= 1'b0;
                state_q  <= S_READ_ACK;
              end else begin
                // shift_q[7] is the bit just sent; present the next one
                sda_oe_q <= ~shift_q[6];
                shift_q  <= {shift_q[6:0], 1'b0};
              end
            end
          end
          S_READ_ACK: begin
            if (scl_rise && sda_s2_q) begin
              state_q <= S_IDLE;
            end else if (scl_fall) begin
              shift_q   <= tx_data;
              tx_ack_q  <= 1'b1;
              sda_oe_q  <= ~tx_data[7];
              bit_cnt_q <= 4'd0;
              state_q   <= S_READ;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            sda_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ack   = tx_ack_q;
  assign busy     = (state_q != S_IDLE);

endmodule
